// File: rtl/polygon_pkg.sv
// Shared types for the polygon fill path: coordinates, vertex counts and loader state.
package polygon_pkg;

    localparam int unsigned MAX_NUM_VERTICES = 32;
    localparam int unsigned MIN_NUM_VERTICES = 3;

    typedef logic signed [31:0] coord_t;
    typedef logic [$clog2(MAX_NUM_VERTICES + 1) - 1:0] count_t;

    typedef enum logic {
        FILL    = 1'b0,
        PENDING = 1'b1
    } loader_state_e;

endpackage

// File: rtl/polygon_vertex_loader_if.sv
// Vertex stream from the physics/update logic into the loader.
interface polygon_vertex_loader_if;
    import polygon_pkg::*;

    logic   vertex_valid;
    logic   vertex_ready;
    coord_t vertex_x;
    coord_t vertex_y;
    logic   vertex_last;

    modport master (
        output vertex_valid,
        output vertex_x,
        output vertex_y,
        output vertex_last,
        input  vertex_ready
    );

    modport slave (
        input  vertex_valid,
        input  vertex_x,
        input  vertex_y,
        input  vertex_last,
        output vertex_ready
    );

endinterface

// File: rtl/polygon_vertex_bank.sv
// Register array of vertex pairs with a single indexed write port and a whole-bank load.
module polygon_vertex_bank
    import polygon_pkg::*;
#(
    parameter int unsigned DEPTH = MAX_NUM_VERTICES
) (
    input  logic                                       clk_in,
    input  logic                                       rst_in,
    input  logic                                       wr_en_in,
    input  logic [((DEPTH > 1) ? $clog2(DEPTH) : 1) - 1:0] wr_idx_in,
    input  coord_t                                     wr_x_in,
    input  coord_t                                     wr_y_in,
    input  logic                                       copy_en_in,
    input  coord_t                                     copy_xs_in [DEPTH],
    input  coord_t                                     copy_ys_in [DEPTH],
    output coord_t                                     xs_out [DEPTH],
    output coord_t                                     ys_out [DEPTH]
);

    coord_t xs_q [DEPTH];
    coord_t ys_q [DEPTH];

    // Whole-bank copy takes priority over the indexed write.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                xs_q[i] <= '0;
                ys_q[i] <= '0;
            end
        end else if (copy_en_in) begin
            xs_q <= copy_xs_in;
            ys_q <= copy_ys_in;
        end else if (wr_en_in) begin
            xs_q[wr_idx_in] <= wr_x_in;
            ys_q[wr_idx_in] <= wr_y_in;
        end
    end

    assign xs_out = xs_q;
    assign ys_out = ys_q;

endmodule

// File: rtl/polygon_vertex_loader.sv
// Double-buffered vertex loader: fills a shadow bank, publishes it to the renderer at frame start.
module polygon_vertex_loader
    import polygon_pkg::*;
#(
    parameter int unsigned MAX_NUM_VERTICES = polygon_pkg::MAX_NUM_VERTICES,
    parameter int unsigned MIN_NUM_VERTICES = polygon_pkg::MIN_NUM_VERTICES
) (
    input  logic                                        clk_in,
    input  logic                                        rst_in,
    input  logic                                        frame_start_in,
    polygon_vertex_loader_if.slave                      vertex,
    output coord_t                                      xs_out [MAX_NUM_VERTICES],
    output coord_t                                      ys_out [MAX_NUM_VERTICES],
    output logic [$clog2(MAX_NUM_VERTICES + 1) - 1:0]   num_points_out,
    output logic                                        polygon_valid_out,
    output logic                                        error_out
);

    localparam int unsigned CNT_W = $clog2(MAX_NUM_VERTICES + 1);
    localparam int unsigned IDX_W = (MAX_NUM_VERTICES > 1) ? $clog2(MAX_NUM_VERTICES) : 1;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_NUM_VERTICES);
    localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_NUM_VERTICES);

    loader_state_e    state_q, state_d;
    logic [CNT_W-1:0] wr_count_q, wr_count_d;
    logic [CNT_W-1:0] pending_count_q, pending_count_d;
    logic [CNT_W-1:0] num_points_q, num_points_d;
    logic             overflow_q, overflow_d;
    logic             polygon_valid_q, polygon_valid_d;
    logic             error_q, error_d;

    logic             ready;
    logic             accept;
    logic             at_max;
    logic             shadow_wr;
    logic             commit;
    logic [CNT_W-1:0] count_next;

    coord_t shadow_xs [MAX_NUM_VERTICES];
    coord_t shadow_ys [MAX_NUM_VERTICES];

    assign ready      = (state_q == FILL);
    assign accept     = vertex.vertex_valid && ready;
    assign at_max     = (wr_count_q == MAX_CNT);
    assign shadow_wr  = accept && !at_max;
    assign count_next = at_max ? wr_count_q : wr_count_q + 1'b1;
    assign commit     = (state_q == PENDING) && frame_start_in;

    always_comb begin
        state_d         = state_q;
        wr_count_d      = wr_count_q;
        pending_count_d = pending_count_q;
        num_points_d    = num_points_q;
        overflow_d      = overflow_q;
        polygon_valid_d = polygon_valid_q;
        error_d         = 1'b0;

        if (accept) begin
            if (vertex.vertex_last) begin
                // A vertex arriving at a full bank counts as overflow even when it is the last one.
                if (overflow_q || at_max || (count_next < MIN_CNT)) begin
                    error_d    = 1'b1;
                    wr_count_d = '0;
                    overflow_d = 1'b0;
                end else begin
                    pending_count_d = count_next;
                    state_d         = PENDING;
                end
            end else begin
                wr_count_d = count_next;
                overflow_d = overflow_q | at_max;
            end
        end

        if (commit) begin
            num_points_d    = pending_count_q;
            polygon_valid_d = 1'b1;
            wr_count_d      = '0;
            state_d         = FILL;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q         <= FILL;
            wr_count_q      <= '0;
            pending_count_q <= '0;
            num_points_q    <= '0;
            overflow_q      <= 1'b0;
            polygon_valid_q <= 1'b0;
            error_q         <= 1'b0;
        end else begin
            state_q         <= state_d;
            wr_count_q      <= wr_count_d;
            pending_count_q <= pending_count_d;
            num_points_q    <= num_points_d;
            overflow_q      <= overflow_d;
            polygon_valid_q <= polygon_valid_d;
            error_q         <= error_d;
        end
    end

    polygon_vertex_bank #(
        .DEPTH(MAX_NUM_VERTICES)
    ) u_shadow_bank (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .wr_en_in  (shadow_wr),
        .wr_idx_in (wr_count_q[IDX_W-1:0]),
        .wr_x_in   (vertex.vertex_x),
        .wr_y_in   (vertex.vertex_y),
        .copy_en_in(1'b0),
        .copy_xs_in(shadow_xs),
        .copy_ys_in(shadow_ys),
        .xs_out    (shadow_xs),
        .ys_out    (shadow_ys)
    );

    polygon_vertex_bank #(
        .DEPTH(MAX_NUM_VERTICES)
    ) u_published_bank (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .wr_en_in  (1'b0),
        .wr_idx_in ('0),
        .wr_x_in   ('0),
        .wr_y_in   ('0),
        .copy_en_in(commit),
        .copy_xs_in(shadow_xs),
        .copy_ys_in(shadow_ys),
        .xs_out    (xs_out),
        .ys_out    (ys_out)
    );

    assign vertex.vertex_ready = ready;
    assign num_points_out      = num_points_q;
    assign polygon_valid_out   = polygon_valid_q;
    assign error_out           = error_q;

endmodule

// File: tb/tb_polygon_vertex_loader.sv
// Scoreboard bench: polygon-level reference model predicts errors, commits and resets.
module tb_polygon_vertex_loader;
    import polygon_pkg::*;

    localparam int MAXV = 4;
    localparam int MINV = 3;
    localparam int EV_ERR = 0;
    localparam int EV_COMMIT = 1;
    localparam int EV_RESET = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic fs = 1'b0;
    coord_t xs [MAXV];
    coord_t ys [MAXV];
    logic [$clog2(MAXV + 1) - 1:0] np;
    logic pv;
    logic err;

    polygon_vertex_loader_if vif();

    polygon_vertex_loader #(
        .MAX_NUM_VERTICES(MAXV),
        .MIN_NUM_VERTICES(MINV)
    ) dut (
        .clk_in           (clk),
        .rst_in           (rst),
        .frame_start_in   (fs),
        .vertex           (vif),
        .xs_out           (xs),
        .ys_out           (ys),
        .num_points_out   (np),
        .polygon_valid_out(pv),
        .error_out        (err)
    );

    always #5 clk = ~clk;

    // Reference model state (polygon-level view).
    int     cyc = 0;
    bit     m_pending = 1'b0;
    int     m_tries = 0;
    coord_t m_x [$];
    coord_t m_y [$];

    int     ev_kind [$];
    int     ev_due [$];
    int     ev_cnt [$];
    coord_t ev_xs [$];
    coord_t ev_ys [$];

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_pending = 1'b0;
            m_tries = 0;
            m_x.delete();
            m_y.delete();
            ev_kind.push_back(EV_RESET); ev_due.push_back(cyc); ev_cnt.push_back(0);
        end else if (m_pending) begin
            if (fs) begin
                ev_kind.push_back(EV_COMMIT); ev_due.push_back(cyc); ev_cnt.push_back(m_x.size());
                foreach (m_x[i]) begin
                    ev_xs.push_back(m_x[i]);
                    ev_ys.push_back(m_y[i]);
                end
                m_x.delete();
                m_y.delete();
                m_pending = 1'b0;
            end
        end else if (vif.vertex_valid) begin
            m_tries++;
            if (m_x.size() < MAXV) begin
                m_x.push_back(vif.vertex_x);
                m_y.push_back(vif.vertex_y);
            end
            if (vif.vertex_last) begin
                if (m_tries > MAXV || m_x.size() < MINV) begin
                    ev_kind.push_back(EV_ERR); ev_due.push_back(cyc); ev_cnt.push_back(0);
                    m_x.delete();
                    m_y.delete();
                end else begin
                    m_pending = 1'b1;
                end
                m_tries = 0;
            end
        end
    end

    // Monitor: consumes scoreboard events and checks outputs every cycle.
    int     total = 0;
    int     bad = 0;
    int     rd = 0;
    int     vrd = 0;
    int     pub_cnt = 0;
    bit     pub_valid = 1'b0;
    coord_t pub_x [MAXV];
    coord_t pub_y [MAXV];

    task automatic chk(input string name, input longint got, input longint want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0d want %0d", name, cyc, got, want);
        end
    endtask

    initial begin
        forever begin
            bit exp_err;
            int mm;
            @(negedge clk);
            exp_err = 1'b0;
            if (rd < ev_kind.size() && ev_due[rd] == cyc) begin
                if (ev_kind[rd] == EV_ERR) begin
                    exp_err = 1'b1;
                end else if (ev_kind[rd] == EV_COMMIT) begin
                    pub_cnt = ev_cnt[rd];
                    pub_valid = 1'b1;
                    for (int i = 0; i < pub_cnt; i++) begin
                        pub_x[i] = ev_xs[vrd + i];
                        pub_y[i] = ev_ys[vrd + i];
                    end
                    vrd += pub_cnt;
                end else begin
                    pub_cnt = 0;
                    pub_valid = 1'b0;
                    mm = 0;
                    for (int i = 0; i < MAXV; i++) begin
                        if (xs[i] != 0 || ys[i] != 0) mm++;
                    end
                    chk("reset_bank_nonzero", mm, 0);
                end
                rd++;
            end
            chk("error_out", err, exp_err);
            chk("vertex_ready", vif.vertex_ready, !m_pending);
            chk("num_points", int'(np), pub_cnt);
            chk("polygon_valid", pv, pub_valid);
            mm = 0;
            for (int i = 0; i < pub_cnt; i++) begin
                if (xs[i] != pub_x[i] || ys[i] != pub_y[i]) mm++;
            end
            chk("published_bank", mm, 0);
        end
    end

    // Stimulus.
    task automatic tick(input bit f);
        vif.vertex_valid = 1'b0;
        vif.vertex_last = 1'b0;
        fs = f;
        @(negedge clk);
        fs = 1'b0;
    endtask

    task automatic send(input int x, input int y, input bit last, input bit f);
        int n;
        n = 0;
        vif.vertex_valid = 1'b1;
        vif.vertex_x = x;
        vif.vertex_y = y;
        vif.vertex_last = last;
        fs = f;
        while (!vif.vertex_ready) begin
            @(negedge clk);
            fs = ($urandom_range(0, 2) == 0);
            n++;
            if (n > 300) begin
                $display("FAIL send_timeout: ready stayed low for %0d cycles, want high", n);
                $fatal(1, "handshake timeout");
            end
        end
        @(negedge clk);
        vif.vertex_valid = 1'b0;
        vif.vertex_last = 1'b0;
        fs = 1'b0;
    endtask

    task automatic do_reset();
        vif.vertex_valid = 1'b0;
        vif.vertex_last = 1'b0;
        fs = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        vif.vertex_valid = 1'b0;
        vif.vertex_x = '0;
        vif.vertex_y = '0;
        vif.vertex_last = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick(1'b1);

        // Square then commit.
        send(0, 0, 1'b0, 1'b0);
        send(100, 0, 1'b0, 1'b0);
        send(100, 100, 1'b0, 1'b0);
        send(0, 100, 1'b1, 1'b0);
        tick(1'b1);
        tick(1'b0);

        // Triangle held pending across a long gap.
        send(-5, 7, 1'b0, 1'b0);
        send(40, -3, 1'b0, 1'b0);
        send(12, 60, 1'b1, 1'b0);
        for (int i = 0; i < 50; i++) tick(1'b0);
        tick(1'b1);
        tick(1'b0);

        // Too few vertices.
        send(1, 2, 1'b0, 1'b0);
        send(3, 4, 1'b1, 1'b0);
        tick(1'b0);

        // Overflow, then a full-size polygon.
        for (int i = 0; i < 5; i++) send(i * 10, -i, (i == 4), 1'b0);
        tick(1'b1);
        for (int i = 0; i < 4; i++) send(-i * 7, i * 3, (i == 3), 1'b0);
        tick(1'b1);
        tick(1'b0);

        // Last vertex coincides with frame start: commit waits for the next pulse.
        send(9, 9, 1'b0, 1'b0);
        send(8, -8, 1'b0, 1'b1);
        send(-7, 7, 1'b1, 1'b1);
        tick(1'b0);
        tick(1'b1);
        tick(1'b0);

        // Reset while pending with a published polygon.
        send(11, 22, 1'b0, 1'b0);
        send(33, 44, 1'b0, 1'b0);
        send(55, 66, 1'b1, 1'b0);
        tick(1'b0);
        do_reset();
        tick(1'b0);

        // Randomized polygons with random gaps and frame pulses.
        for (int p = 0; p < 60; p++) begin
            int n;
            if ($urandom_range(0, 29) == 0) do_reset();
            n = $urandom_range(1, MAXV + 2);
            for (int v = 0; v < n; v++) begin
                if ($urandom_range(0, 3) == 0) tick($urandom_range(0, 3) == 0);
                send($urandom, $urandom, (v == n - 1), $urandom_range(0, 7) == 0);
            end
        end
        for (int i = 0; i < 4; i++) tick(1'b1);
        tick(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/polygon_vertex_loader.md
# polygon_vertex_loader

Producer-side buffer for the polygon fill renderer. Accepts polygon vertices one per handshake from game/physics logic, assembles them in a shadow bank, and publishes a complete, stable vertex set (xs, ys, count) to the renderer only at a frame boundary. The renderer never sees a half-written polygon. Sits between the physics/update logic and `draw_polygon`, driving its `xs_in`, `ys_in` and `num_points_in` directly.

## Interface
- MAX_NUM_VERTICES, 32, capacity of both banks; must match the renderer.
- MIN_NUM_VERTICES, 3, smallest polygon that is committed.
- clk_in  input  1  system clock (pixel clock domain).
- rst_in  input  1  reset. One clock; reset is synchronous and active-high.
- frame_start_in  input  1  one-cycle pulse at the start of vertical blanking; the only commit point.
- vertex_valid_in  input  1  writer presents a vertex.
- vertex_ready_out  output  1  loader can accept a vertex.
- vertex_x_in  input  32 signed  world x of the vertex.
- vertex_y_in  input  32 signed  world y of the vertex.
- vertex_last_in  input  1  marks the final vertex of the polygon; qualified by valid.
- xs_out  output  32 signed x MAX_NUM_VERTICES  published x coordinates, in order.
- ys_out  output  32 signed x MAX_NUM_VERTICES  published y coordinates.
- num_points_out  output  $clog2(MAX_NUM_VERTICES+1)  published vertex count.
- polygon_valid_out  output  1  at least one polygon has been published since reset.
- error_out  output  1  one-cycle pulse when a polygon is rejected.

## Operation
- A transfer occurs on a rising edge with vertex_valid_in && vertex_ready_out. Writer holds data stable while valid && !ready.
- States: FILL (ready=1, accepting into shadow bank), PENDING (ready=0, shadow complete, waiting for frame_start_in).
- In FILL, each transfer writes shadow[wr_count] and increments wr_count (saturating at MAX_NUM_VERTICES).
- Overflow: a transfer with wr_count == MAX_NUM_VERTICES sets an overflow flag. The vertex is discarded and acceptance continues until last.
- On the transfer with vertex_last_in:
  - If overflow is set, or the final count is below MIN_NUM_VERTICES: pulse error_out next cycle, clear wr_count and overflow, stay in FILL.
  - Otherwise: latch the final count into pending_count and go to PENDING.
- In PENDING, on frame_start_in: copy the shadow bank to xs_out/ys_out, set num_points_out = pending_count, set polygon_valid_out = 1, clear wr_count, return to FILL.
- frame_start_in in FILL has no effect. The published bank is unchanged, and a partially loaded polygon keeps loading.
- Published bank entries at indices >= num_points_out hold stale data. The renderer honours num_points_out only.
- Coordinates pass through unmodified, with no scaling or clamping.

## Timing
- Reset values: vertex_ready_out 1 (state FILL), xs_out/ys_out all 0, num_points_out 0, polygon_valid_out 0, error_out 0, wr_count 0, overflow 0.
- Reset mid-load or in PENDING discards the shadow polygon. The published bank also returns to reset values.
- vertex_ready_out is a decode of the registered state. It falls in the cycle after the accepted last vertex.
- Commit latency: outputs change on the edge that samples frame_start_in while in PENDING. Values are visible the cycle after that edge.
- Last vertex accepted in the same cycle as frame_start_in: the state is still FILL on that edge, so the commit waits for the next frame_start_in.
- error_out is registered: it is high for exactly the one cycle after the rejecting last transfer.
- Throughput: one vertex per cycle in FILL. Back-to-back polygons are limited to one per frame.

## Structure
- Shared package `polygon_pkg`:
  - coordinate typedef (signed 32-bit);
  - vertex count typedef sized $clog2(MAX_NUM_VERTICES+1);
  - loader state enum {FILL, PENDING};
  - MIN_NUM_VERTICES default.
  - `draw_polygon` / `in_polygon` reuse the coordinate and count typedefs.
- One sub-module: `polygon_vertex_bank`. It is a MAX_NUM_VERTICES-entry register array with indexed write and whole-array copy enable, instantiated twice (shadow, published). The FSM, counter and handshake stay in the top level.

## Test plan
- Load square (0,0),(100,0),(100,100),(0,100), last on 4th; pulse frame_start_in → next cycle num_points_out=4, xs_out[1]=100, ys_out[2]=100, polygon_valid_out=1, ready back to 1.
- Load triangle, then hold frame_start_in low 50 cycles → ready=0 throughout, published outputs unchanged; commit on the following pulse.
- Send 2 vertices with last on 2nd → error_out high one cycle, num_points_out stays 0, ready stays 1.
- With MAX_NUM_VERTICES=4, send 5 vertices, last on 5th → error_out pulse, no commit. A following valid 4-vertex load commits count 4.
- Last vertex and frame_start_in in the same cycle → no commit. The next frame_start_in commits it.
- Assert rst_in while in PENDING with a prior polygon published → all outputs return to reset values, ready=1 the cycle after reset.
